event_chain_monitor: RTL and testbench

- Receive-side checker for a sequential event chain, where stage i fires stage i+1 in order from 0 to N-1.
- Samples one single-cycle pulse per stage and keeps a sticky per-stage "triggered" mask.
- Checks that pulses arrive strictly in order, one per cycle, with no duplicates.
- Reports done when stage N-1 fires; otherwise reports the first violation with index and cause.

---
 rtl/event_chain_monitor.sv | 146 ++++++++++++++
 tb/tb_event_chain_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/event_chain_monitor.sv
// In-order event chain checker with a sticky per-stage mask. Responses are registered one cycle after the ev sample; there is no backpressure.
// Optional stall timeout enabled by defining EVENT_CHAIN_MONITOR_TIMEOUT_EN.
module event_chain_monitor #(
  parameter int N       = 100,
  parameter int IW      = $clog2(N),
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [N-1:0]  ev,
  output logic [N-1:0]  triggered,
  output logic [IW-1:0] next_idx,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [IW-1:0] err_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_ORDER   = 2'd1;
  localparam logic [1:0] E_DUP     = 2'd2;
  localparam logic [1:0] E_TIMEOUT = 2'd3;

  if (N < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("event_chain_monitor: N must be >= 2 and TIMEOUT >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  triggered_q, triggered_d;
  logic [IW-1:0] next_idx_q, next_idx_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [IW-1:0] err_idx_q, err_idx_d;

  logic [N-1:0]  exp_mask;
  logic [N-1:0]  bad;
  logic [IW-1:0] bad_idx;

`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
`endif

  // bad is every pulse other than the one we are waiting for; its lowest bit is the reported index.
  always_comb begin
    exp_mask = {{(N-1){1'b0}}, 1'b1} << next_idx_q;
    bad      = ev & ~exp_mask;
    bad_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bad[i]) bad_idx = IW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    triggered_d = triggered_q;
    next_idx_d  = next_idx_q;
    err_code_d  = err_code_q;
    err_idx_d   = err_idx_q;
`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
    stall_d     = (state_q == S_TRACK) ? stall_q : '0;
`endif
    if (clear) begin
      state_d     = S_IDLE;
      triggered_d = '0;
      next_idx_d  = '0;
      err_code_d  = E_NONE;
      err_idx_d   = '0;
`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
      stall_d     = '0;
`endif
    end else begin
      case (state_q)
        // IDLE behaves as TRACK waiting on stage 0; triggered is empty so duplicates cannot occur there.
        S_IDLE, S_TRACK: begin
          if (|bad) begin
            state_d    = S_ERROR;
            err_idx_d  = bad_idx;
            err_code_d = triggered_q[bad_idx] ? E_DUP : E_ORDER;
          end else if (|(ev & exp_mask)) begin
            triggered_d = triggered_q | exp_mask;
`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
            stall_d     = '0;
`endif
            if (next_idx_q == IW'(N - 1)) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_TRACK;
              next_idx_d = next_idx_q + IW'(1);
            end
          end
`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
          else if (state_q == S_TRACK) begin
            if (stall_q == SW'(TIMEOUT - 1)) begin
              state_d    = S_ERROR;
              err_code_d = E_TIMEOUT;
              err_idx_d  = next_idx_q;
              stall_d    = '0;
            end else begin
              stall_d = stall_q + SW'(1);
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      triggered_q <= '0;
      next_idx_q  <= '0;
      err_code_q  <= E_NONE;
      err_idx_q   <= '0;
`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      triggered_q <= triggered_d;
      next_idx_q  <= next_idx_d;
      err_code_q  <= err_code_d;
      err_idx_q   <= err_idx_d;
`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign triggered = triggered_q;
  assign next_idx  = next_idx_q;
  assign busy      = (state_q == S_TRACK);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);
  assign err_code  = err_code_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_event_chain_monitor.sv
// Directed bench: a 4-stage instance (TIMEOUT=8) for protocol cases and a 100-stage instance for a long chain.
module tb_event_chain_monitor;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       clr_s = 1'b0;
  logic [3:0] ev_s  = '0;
  logic [3:0] trig_s;
  logic [1:0] nidx_s, ecode_s, eidx_s;
  logic       busy_s, done_s, err_s;

  logic        clr_b = 1'b0;
  logic [99:0] ev_b  = '0;
  logic [99:0] trig_b;
  logic [6:0]  nidx_b, eidx_b;
  logic [1:0]  ecode_b;
  logic        busy_b, done_b, err_b;

  int n_assert = 0;
  int n_fail   = 0;

  event_chain_monitor #(.N(4), .TIMEOUT(8)) u_small (
    .clk(clk), .rst_n(rst_n), .clear(clr_s), .ev(ev_s),
    .triggered(trig_s), .next_idx(nidx_s), .busy(busy_s), .done(done_s),
    .err(err_s), .err_code(ecode_s), .err_idx(eidx_s)
  );

  event_chain_monitor #(.N(100)) u_big (
    .clk(clk), .rst_n(rst_n), .clear(clr_b), .ev(ev_b),
    .triggered(trig_b), .next_idx(nidx_b), .busy(busy_b), .done(done_b),
    .err(err_b), .err_code(ecode_b), .err_idx(eidx_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] t, input logic [1:0] ni,
                        input logic b, input logic d, input logic e,
                        input logic [1:0] ec, input logic [1:0] ei);
    chk({tag, "_trig"},  128'(trig_s),  128'(t));
    chk({tag, "_nidx"},  128'(nidx_s),  128'(ni));
    chk({tag, "_busy"},  128'(busy_s),  128'(b));
    chk({tag, "_done"},  128'(done_s),  128'(d));
    chk({tag, "_err"},   128'(err_s),   128'(e));
    chk({tag, "_ecode"}, 128'(ecode_s), 128'(ec));
    chk({tag, "_eidx"},  128'(eidx_s),  128'(ei));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    ev_s = v;
    tick();
    ev_s = '0;
  endtask

  task automatic do_clear();
    clr_s = 1'b1;
    tick();
    clr_s = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk_st("reset", 4'b0000, 2'd0, 0, 0, 0, 2'd0, 2'd0);
    chk("big_reset_trig", 128'(trig_b), 128'(0));
    chk("big_reset_busy", 128'(busy_b), 128'(0));
    rst_n = 1'b1;
    tick();
    chk_st("idle_hold", 4'b0000, 2'd0, 0, 0, 0, 2'd0, 2'd0);

    // full in-order chain, then an ignored pulse in DONE
    pulse(4'b0001); chk_st("chain_s0", 4'b0001, 2'd1, 1, 0, 0, 2'd0, 2'd0);
    pulse(4'b0010); chk_st("chain_s1", 4'b0011, 2'd2, 1, 0, 0, 2'd0, 2'd0);
    pulse(4'b0100); chk_st("chain_s2", 4'b0111, 2'd3, 1, 0, 0, 2'd0, 2'd0);
    pulse(4'b1000); chk_st("chain_done", 4'b1111, 2'd3, 0, 1, 0, 2'd0, 2'd0);
    pulse(4'b0001); chk_st("done_sticky", 4'b1111, 2'd3, 0, 1, 0, 2'd0, 2'd0);

    do_clear();     chk_st("clear_done", 4'b0000, 2'd0, 0, 0, 0, 2'd0, 2'd0);

    // skip ahead: stage 2 while expecting stage 1
    pulse(4'b0001);
    pulse(4'b0100); chk_st("out_of_order", 4'b0001, 2'd1, 0, 0, 1, 2'd1, 2'd2);
    pulse(4'b0010); chk_st("err_sticky", 4'b0001, 2'd1, 0, 0, 1, 2'd1, 2'd2);

    // duplicate of stage 0 alongside expected-but-unrecorded? no: next is 2, ev=0011 -> dup at 0
    do_clear();
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0011); chk_st("duplicate", 4'b0011, 2'd2, 0, 0, 1, 2'd2, 2'd0);

    // two pulses in IDLE, lowest bad bit is 1
    do_clear();
    pulse(4'b0110); chk_st("idle_multi", 4'b0000, 2'd0, 0, 0, 1, 2'd1, 2'd1);

    // expected bit plus another: error, expected bit not recorded
    do_clear();
    pulse(4'b0001);
    pulse(4'b1010); chk_st("track_multi", 4'b0001, 2'd1, 0, 0, 1, 2'd1, 2'd3);

    // clear wins over a same-cycle expected pulse
    do_clear();
    pulse(4'b0001);
    clr_s = 1'b1; ev_s = 4'b0010;
    tick();
    clr_s = 1'b0; ev_s = '0;
    chk_st("clear_prio", 4'b0000, 2'd0, 0, 0, 0, 2'd0, 2'd0);

    // async reset mid-chain, then error in IDLE, then clear out of ERROR, then a full chain
    pulse(4'b0001);
    rst_n = 1'b0;
    #1;
    chk_st("async_rst", 4'b0000, 2'd0, 0, 0, 0, 2'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse(4'b0100); chk_st("idle_ooo", 4'b0000, 2'd0, 0, 0, 1, 2'd1, 2'd2);
    do_clear();     chk_st("clear_err", 4'b0000, 2'd0, 0, 0, 0, 2'd0, 2'd0);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    pulse(4'b1000); chk_st("rechain_done", 4'b1111, 2'd3, 0, 1, 0, 2'd0, 2'd0);

    // stall of 8 idle cycles after stage 0
    do_clear();
    pulse(4'b0001);
    repeat (7) tick();
    chk_st("stall7", 4'b0001, 2'd1, 1, 0, 0, 2'd0, 2'd0);
    tick();
`ifdef EVENT_CHAIN_MONITOR_TIMEOUT_EN
    chk_st("timeout", 4'b0001, 2'd1, 0, 0, 1, 2'd3, 2'd1);
`else
    chk_st("no_timeout", 4'b0001, 2'd1, 1, 0, 0, 2'd0, 2'd0);
`endif

    // pulse lands on the 8th cycle and is accepted
    do_clear();
    pulse(4'b0001);
    repeat (7) tick();
    pulse(4'b0010); chk_st("pulse_at_limit", 4'b0011, 2'd2, 1, 0, 0, 2'd0, 2'd0);
    repeat (7) tick();
    chk_st("stall_restart", 4'b0011, 2'd2, 1, 0, 0, 2'd0, 2'd0);

    // 100-stage chain with random gaps
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(5, 0)) tick();
      ev_b = '0;
      ev_b[i] = 1'b1;
      tick();
      ev_b = '0;
      if (i == 49) begin
        chk("big_mid_nidx", 128'(nidx_b), 128'(50));
        chk("big_mid_busy", 128'(busy_b), 128'(1));
      end
    end
    chk("big_done", 128'(done_b), 128'(1));
    chk("big_trig", 128'(trig_b), {28'd0, {100{1'b1}}});
    chk("big_nidx", 128'(nidx_b), 128'(99));
    chk("big_err",  128'(err_b),  128'(0));
    chk("big_busy", 128'(busy_b), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
